// File: rtl/xor_unit.sv
// -----------------------------------------------------------------------------
// xor_unit
//
// Bitwise XOR stage with compare side-results and one cycle of latency.
// When in_valid is high at a rising clk edge, the pair (in_1, in_2) is captured
// and four results appear together after that edge:
//   out        - in_1 ^ in_2
//   equal      - operands were identical (XOR word all zero)
//   diff_count - Hamming distance, i.e. popcount of the XOR word
//   parity     - reduction XOR of the XOR word (== diff_count[0])
// out_valid pulses high for each accepted pair. When in_valid is low the
// result registers hold and out_valid drops. No backpressure, no stall.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   qualifies in_1/in_2 this cycle
//   in_1, in_2 in   WIDTH-bit operands
//   out_valid  out  one-cycle-delayed in_valid
//   out        out  registered XOR word
//   equal      out  registered equality flag (1 in reset)
//   diff_count out  registered popcount, CNT_W bits
//   parity     out  registered parity of the XOR word
// -----------------------------------------------------------------------------
module xor_unit #(
  parameter int WIDTH = 8,
  // Derived from WIDTH; wide enough to hold the value WIDTH itself.
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             equal,
  output logic [CNT_W-1:0] diff_count,
  output logic             parity
);

  logic [WIDTH-1:0] xor_w;
  logic [CNT_W-1:0] pop_w;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_d,       out_q;
  logic             equal_d,     equal_q;
  logic [CNT_W-1:0] diff_count_d, diff_count_q;
  logic             parity_d,    parity_q;

  // XOR word and its popcount, formed from the operands ahead of the register
  // so all four results are loaded from the same pair on the same edge.
  always_comb begin
    xor_w = in_1 ^ in_2;
    pop_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_w = pop_w + CNT_W'(xor_w[i]);
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first (here: hold the
    // current value), so no path leaves a signal unassigned and no latch forms.
    out_valid_d  = in_valid;
    out_d        = out_q;
    equal_d      = equal_q;
    diff_count_d = diff_count_q;
    parity_d     = parity_q;
    // Operands are only looked at when qualified, so X on an idle bus never
    // reaches the result registers.
    if (in_valid) begin
      out_d        = xor_w;
      diff_count_d = pop_w;
      equal_d      = (pop_w == '0);
      parity_d     = pop_w[0];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      equal_q      <= 1'b1;  // consistent with out_q == 0
      diff_count_q <= '0;
      parity_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      equal_q      <= equal_d;
      diff_count_q <= diff_count_d;
      parity_q     <= parity_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign equal      = equal_q;
  assign diff_count = diff_count_q;
  assign parity     = parity_q;

endmodule

// File: tb/tb_xor_unit.sv
// -----------------------------------------------------------------------------
// tb_xor_unit
//
// Directed bench for xor_unit. A WIDTH=8 instance carries the main sequence
// (reset, basic XOR, equality/full difference, valid gating, async reset,
// streaming); WIDTH=1, 32 and 64 instances cover the parameter range.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_xor_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH = 8 instance
  logic       v8;
  logic [7:0] a8, b8, o8;
  logic       ov8, eq8, p8;
  logic [3:0] dc8;

  // WIDTH = 1 instance
  logic       v1, a1, b1, o1, ov1, eq1, p1;
  logic [0:0] dc1;

  // WIDTH = 32 instance
  logic        v32;
  logic [31:0] a32, b32, o32;
  logic        ov32, eq32, p32;
  logic [5:0]  dc32;

  // WIDTH = 64 instance
  logic        v64;
  logic [63:0] a64, b64, o64;
  logic        ov64, eq64, p64;
  logic [6:0]  dc64;

  xor_unit #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_1(a8), .in_2(b8),
    .out_valid(ov8), .out(o8), .equal(eq8), .diff_count(dc8), .parity(p8)
  );
  xor_unit #(.WIDTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_1(a1), .in_2(b1),
    .out_valid(ov1), .out(o1), .equal(eq1), .diff_count(dc1), .parity(p1)
  );
  xor_unit #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_1(a32), .in_2(b32),
    .out_valid(ov32), .out(o32), .equal(eq32), .diff_count(dc32), .parity(p32)
  );
  xor_unit #(.WIDTH(64)) u_d64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_1(a64), .in_2(b64),
    .out_valid(ov64), .out(o64), .equal(eq64), .diff_count(dc64), .parity(p64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] e_out, input logic e_eq,
                        input logic [3:0] e_dc, input logic e_par, input logic e_ov);
    check({tag, ".out"},  64'(o8),  64'(e_out));
    check({tag, ".eq"},   64'(eq8), 64'(e_eq));
    check({tag, ".dc"},   64'(dc8), 64'(e_dc));
    check({tag, ".par"},  64'(p8),  64'(e_par));
    check({tag, ".ov"},   64'(ov8), 64'(e_ov));
  endtask

  initial begin
    logic [7:0]  ra, rb, rx;
    logic [31:0] x32;
    logic [63:0] x64;

    // ---- 1. reset held with random inputs and clock running ----
    rst_n = 1'b0;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    v32 = 1'b0; a32 = '0; b32 = '0;
    v64 = 1'b0; a64 = '0; b64 = '0;
    v8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      tick();
    end
    check8("reset_hold", 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ---- 2. basic XOR ----
    a8 = 8'h00; b8 = 8'h55; v8 = 1'b1;
    tick();
    check8("basic_55", 8'h55, 1'b0, 4'd4, 1'b0, 1'b1);
    b8 = 8'hAA;
    tick();
    check8("basic_aa", 8'hAA, 1'b0, 4'd4, 1'b0, 1'b1);

    // ---- 3. equality and full difference ----
    a8 = 8'h3C; b8 = 8'h3C;
    tick();
    check8("equal_3c", 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
    a8 = 8'hFF; b8 = 8'h00;
    tick();
    check8("full_ff", 8'hFF, 1'b0, 4'd8, 1'b0, 1'b1);
    a8 = 8'h01; b8 = 8'h00;
    tick();
    check8("one_bit", 8'h01, 1'b0, 4'd1, 1'b1, 1'b1);

    // ---- 4. valid gating ----
    a8 = 8'h0F; b8 = 8'hF0;
    tick();
    check8("gate_cap", 8'hFF, 1'b0, 4'd8, 1'b0, 1'b1);
    v8 = 1'b0; b8 = 8'h0F;
    tick();
    check8("gate_hold", 8'hFF, 1'b0, 4'd8, 1'b0, 1'b0);
    a8 = 8'hxx; b8 = 8'hxx;
    tick();
    check8("gate_x", 8'hFF, 1'b0, 4'd8, 1'b0, 1'b0);
    a8 = 8'h0F; b8 = 8'h0F; v8 = 1'b1;
    tick();
    check8("gate_resume", 8'h00, 1'b1, 4'd0, 1'b0, 1'b1);

    // ---- async reset mid-stream, between edges ----
    a8 = 8'h12; b8 = 8'h34;   // 0x26: three bits set, odd parity
    tick();
    check8("pre_rst", 8'h26, 1'b0, 4'd3, 1'b1, 1'b1);
    a8 = 8'hC3; b8 = 8'h00;   // in flight, must be discarded
    #3 rst_n = 1'b0;
    #1;
    check8("async_rst", 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    tick();
    check8("rst_discard", 8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // ---- 5. streaming: 16 back-to-back random pairs ----
    ra = 8'($urandom); rb = 8'($urandom);
    a8 = ra; b8 = rb;
    for (int i = 0; i < 16; i++) begin
      tick();
      rx = ra ^ rb;
      check8($sformatf("stream%0d", i), rx, (rx == 8'h00), 4'($countones(rx)),
             ^rx, 1'b1);
      ra = 8'($urandom); rb = 8'($urandom);
      a8 = ra; b8 = rb;
    end
    v8 = 1'b0;

    // ---- 6a. WIDTH = 1, exhaustive ----
    v1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a1 = i[1]; b1 = i[0];
      tick();
      check($sformatf("w1_out%0d", i), 64'(o1),  64'(i[1] ^ i[0]));
      check($sformatf("w1_dc%0d", i),  64'(dc1), 64'(i[1] ^ i[0]));
      check($sformatf("w1_par%0d", i), 64'(p1),  64'(i[1] ^ i[0]));
      check($sformatf("w1_eq%0d", i),  64'(eq1), 64'(i[1] == i[0]));
    end
    v1 = 1'b0;

    // ---- 6b. WIDTH = 32 ----
    v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0;
    tick();
    check("w32_full_out", 64'(o32),  64'hFFFF_FFFF);
    check("w32_full_dc",  64'(dc32), 64'd32);
    check("w32_full_par", 64'(p32),  64'd0);
    check("w32_full_eq",  64'(eq32), 64'd0);
    for (int i = 0; i < 4; i++) begin
      a32 = $urandom; b32 = $urandom;
      x32 = a32 ^ b32;
      tick();
      check($sformatf("w32_out%0d", i), 64'(o32),  64'(x32));
      check($sformatf("w32_dc%0d", i),  64'(dc32), 64'($countones(x32)));
      check($sformatf("w32_par%0d", i), 64'(p32),  64'(^x32));
    end
    v32 = 1'b0;

    // ---- 6c. WIDTH = 64 ----
    v64 = 1'b1; a64 = '1; b64 = '0;
    tick();
    check("w64_full_dc",  64'(dc64), 64'd64);
    check("w64_full_out", o64,       64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) begin
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      x64 = a64 ^ b64;
      tick();
      check($sformatf("w64_out%0d", i), o64,         x64);
      check($sformatf("w64_dc%0d", i),  64'(dc64),   64'($countones(x64)));
      check($sformatf("w64_par%0d", i), 64'(p64),    64'(^x64));
      check($sformatf("w64_ov%0d", i),  64'(ov64),   64'd1);
    end
    v64 = 1'b0;
    tick();
    check("w64_ov_drop", 64'(ov64), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
